// File: rtl/alu_accum_seq_if.sv
// Handshake/bus bundle for alu_accum_seq.
// Master drives i_Go/i_Data/i_Function; slave returns o_ALUout/o_Ovf/o_Busy/o_Done.
interface alu_accum_seq_if #(
    parameter int W = 4
);
    logic           i_Go;
    logic [W-1:0]   i_Data;
    logic [2:0]     i_Function;
    logic [2*W-1:0] o_ALUout;
    logic           o_Ovf;
    logic           o_Busy;
    logic           o_Done;

    modport master (
        output i_Go, i_Data, i_Function,
        input  o_ALUout, o_Ovf, o_Busy, o_Done
    );

    modport slave (
        input  i_Go, i_Data, i_Function,
        output o_ALUout, o_Ovf, o_Busy, o_Done
    );
endinterface

// File: rtl/alu_accum_seq.sv
// Sequential accumulator ALU: 2W-bit result register, W-bit operand, 3-bit op,
// Go/Busy/Done handshake and a W-cycle shift-add multiplier sharing the register.
// Ports: i_Clock, i_Reset_b (sync, active-high), bus (alu_accum_seq_if.slave):
//   i_Go, i_Data[W], i_Function[3] in; o_ALUout[2W], o_Ovf, o_Busy, o_Done out.
// Optional macro ALU_SAT_EN: ADD saturates to all-ones, SUB saturates to 0.
module alu_accum_seq #(
    parameter int W = 4
) (
    input  logic          i_Clock,
    input  logic          i_Reset_b,
    alu_accum_seq_if.slave bus
);
    localparam int RW = 2 * W;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [2:0] F_ADD = 3'b000;
    localparam logic [2:0] F_MUL = 3'b001;
    localparam logic [2:0] F_SHL = 3'b010;
    localparam logic [2:0] F_HLD = 3'b011;
    localparam logic [2:0] F_SUB = 3'b100;
    localparam logic [2:0] F_AND = 3'b101;
    localparam logic [2:0] F_OR  = 3'b110;
    localparam logic [2:0] F_XOR = 3'b111;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [RW-1:0]  r_alu;
    logic [RW-1:0]  r_mcand;
    logic [RW-1:0]  r_pp;
    logic [W-1:0]   r_mplr;
    logic [CW-1:0]  r_cnt;
    logic           r_ovf;
    logic           r_done;

    logic           w_issue;
    logic           w_single;
    logic           w_start;
    logic           w_finish;
    logic [RW-1:0]  w_d;
    logic [RW-1:0]  w_b;
    logic [RW:0]    w_sum;
    logic [RW:0]    w_dif;
    logic [RW-1:0]  w_res;
    logic           w_ovf;
    logic [RW-1:0]  w_pp_nxt;

    assign w_issue  = bus.i_Go && (r_state == S_IDLE);
    assign w_single = w_issue && (bus.i_Function != F_MUL);
    assign w_d      = {{W{1'b0}}, bus.i_Data};
    assign w_b      = {{W{1'b0}}, r_alu[W-1:0]};
    assign w_sum    = {1'b0, r_alu} + {1'b0, w_d};
    // Top bit of the widened difference is the borrow.
    assign w_dif    = {1'b0, r_alu} - {1'b0, w_d};
    assign w_pp_nxt = r_pp + (r_mplr[0] ? r_mcand : '0);

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_finish    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_issue && bus.i_Function == F_MUL) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                if (r_cnt == '0) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        w_res = r_alu;
        w_ovf = 1'b0;
        unique case (bus.i_Function)
            F_ADD: begin
                w_ovf = w_sum[RW];
`ifdef ALU_SAT_EN
                w_res = w_sum[RW] ? '1 : w_sum[RW-1:0];
`else
                w_res = w_sum[RW-1:0];
`endif
            end
            F_SUB: begin
                w_ovf = w_dif[RW];
`ifdef ALU_SAT_EN
                w_res = w_dif[RW] ? '0 : w_dif[RW-1:0];
`else
                w_res = w_dif[RW-1:0];
`endif
            end
            // Shift amounts >= RW naturally yield zero.
            F_SHL: w_res = w_b << bus.i_Data;
            F_HLD: w_res = r_alu;
            F_AND: w_res = r_alu & w_d;
            F_OR:  w_res = r_alu | w_d;
            F_XOR: w_res = r_alu ^ w_d;
            F_MUL: w_res = r_alu;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset_b) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset_b) begin
            r_alu   <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
            r_mcand <= '0;
            r_mplr  <= '0;
            r_pp    <= '0;
            r_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_single) begin
                r_alu  <= w_res;
                r_ovf  <= w_ovf;
                r_done <= 1'b1;
            end
            if (w_start) begin
                r_mcand <= w_b;
                r_mplr  <= bus.i_Data;
                r_pp    <= '0;
                r_cnt   <= CW'(W - 1);
            end
            if (r_state == S_MUL) begin
                r_pp    <= w_pp_nxt;
                r_mcand <= r_mcand << 1;
                r_mplr  <= r_mplr >> 1;
                if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
            end
            // Last step: fold the final partial product straight into the result.
            if (w_finish) begin
                r_alu  <= w_pp_nxt;
                r_ovf  <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign bus.o_ALUout = r_alu;
    assign bus.o_Ovf    = r_ovf;
    assign bus.o_Busy   = (r_state == S_MUL);
    assign bus.o_Done   = r_done;
endmodule

// File: tb/tb_alu_accum_seq.sv
// Self-checking bench for alu_accum_seq (W=4).
// Directed scenarios plus randomized ops against an arithmetic reference model.
module tb_alu_accum_seq;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_accum_seq_if #(.W(W)) bus ();

    alu_accum_seq #(.W(W)) dut (
        .i_Clock   (clk),
        .i_Reset_b (rst),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int m_r      = 0;
    bit m_ovf    = 1'b0;

    // Reference: plain integer arithmetic on an 8-bit accumulator.
    function automatic void model(input int f, input int d);
        int b;
        int s;
        b = m_r % 16;
        case (f)
            0: begin
                s = m_r + d;
                m_ovf = (s > 255);
`ifdef ALU_SAT_EN
                m_r = (s > 255) ? 255 : s;
`else
                m_r = s % 256;
`endif
            end
            1: begin m_r = d * b; m_ovf = 1'b0; end
            2: begin m_r = (d >= 8) ? 0 : ((b << d) % 256); m_ovf = 1'b0; end
            3: m_ovf = 1'b0;
            4: begin
                m_ovf = (d > m_r);
`ifdef ALU_SAT_EN
                m_r = (d > m_r) ? 0 : m_r - d;
`else
                m_r = (m_r - d + 256) % 256;
`endif
            end
            5: begin m_r = m_r & d; m_ovf = 1'b0; end
            6: begin m_r = m_r | d; m_ovf = 1'b0; end
            default: begin m_r = m_r ^ d; m_ovf = 1'b0; end
        endcase
    endfunction

    function automatic logic [2*W+2:0] act();
        return {bus.o_ALUout, bus.o_Ovf, bus.o_Busy, bus.o_Done};
    endfunction

    function automatic logic [2*W+2:0] expv(input bit busy, input bit done);
        logic [31:0] r;
        r = m_r;
        return {r[7:0], m_ovf, busy, done};
    endfunction

    task automatic issue(input int f, input int d);
        logic [31:0] fv;
        logic [31:0] dv;
        fv = f;
        dv = d;
        bus.i_Go       = 1'b1;
        bus.i_Function = fv[2:0];
        bus.i_Data     = dv[W-1:0];
        @(posedge clk);
        #1;
        bus.i_Go = 1'b0;
    endtask

    task automatic single(input int f, input int d, input string nm);
        model(f, d);
        issue(f, d);
        n_checks++;
        if (act() !== expv(1'b0, 1'b1)) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act(), expv(1'b0, 1'b1));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_Go = 1'b1;
        bus.i_Function = 3'b000;
        bus.i_Data = 4'h5;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (act() !== '0) begin
            n_fail++;
            $display("FAIL reset: got %h want 0", act());
        end
        rst = 1'b0;
        bus.i_Go = 1'b0;
        m_r = 0;
        m_ovf = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (act() !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got %h want 0", act());
        end
    endtask

    task automatic test_add_shl();
        single(0, 5, "add5");
        n_checks++;
        if (bus.o_ALUout !== 8'h05) begin
            n_fail++;
            $display("FAIL add5_lit: got %h want 05", bus.o_ALUout);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (act() !== expv(1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL done_pulse: got %h want %h", act(), expv(1'b0, 1'b0));
        end
        single(2, 3, "shl3");
        n_checks++;
        if (bus.o_ALUout !== 8'h28) begin
            n_fail++;
            $display("FAIL shl3_lit: got %h want 28", bus.o_ALUout);
        end
        single(2, 9, "shl9");
        n_checks++;
        if (bus.o_ALUout !== 8'h00) begin
            n_fail++;
            $display("FAIL shl9_lit: got %h want 00", bus.o_ALUout);
        end
    endtask

    task automatic test_mul();
        single(0, 13, "mul_setup");
        model(1, 11);
        issue(1, 11);
        bus.i_Go = 1'b1;
        bus.i_Function = 3'b000;
        bus.i_Data = 4'h1;
        n_checks++;
        if ({bus.o_ALUout, bus.o_Busy, bus.o_Done} !== {8'h0D, 2'b10}) begin
            n_fail++;
            $display("FAIL mul_busy0: got %h want 0d/busy", act());
        end
        for (int i = 1; i < W; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({bus.o_ALUout, bus.o_Busy, bus.o_Done} !== {8'h0D, 2'b10}) begin
                n_fail++;
                $display("FAIL mul_busy%0d: got %h want 0d/busy", i, act());
            end
        end
        @(posedge clk);
        #1;
        bus.i_Go = 1'b0;
        n_checks++;
        if (act() !== {8'h8F, 3'b001}) begin
            n_fail++;
            $display("FAIL mul_done: got %h want %h", act(), {8'h8F, 3'b001});
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (act() !== expv(1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL mul_go_dropped: got %h want %h", act(), expv(1'b0, 1'b0));
        end
    endtask

    task automatic test_ovf();
        single(5, 0, "ovf_and0");
        single(0, 15, "ovf_add15");
        single(2, 4, "ovf_shl4");
        single(6, 14, "ovf_or14");
        single(0, 5, "ovf_add5");
        n_checks++;
`ifdef ALU_SAT_EN
        if ({bus.o_ALUout, bus.o_Ovf} !== {8'hFF, 1'b1}) begin
`else
        if ({bus.o_ALUout, bus.o_Ovf} !== {8'h03, 1'b1}) begin
`endif
            n_fail++;
            $display("FAIL ovf_add_lit: got %h/%b", bus.o_ALUout, bus.o_Ovf);
        end
        single(5, 15, "ovf_and_clr");
        n_checks++;
        if (bus.o_Ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b want 0", bus.o_Ovf);
        end
    endtask

    task automatic test_sub();
        single(5, 0, "sub_and0");
        single(0, 2, "sub_add2");
        single(4, 4, "sub4");
        n_checks++;
`ifdef ALU_SAT_EN
        if ({bus.o_ALUout, bus.o_Ovf} !== {8'h00, 1'b1}) begin
`else
        if ({bus.o_ALUout, bus.o_Ovf} !== {8'hFE, 1'b1}) begin
`endif
            n_fail++;
            $display("FAIL sub_lit: got %h/%b", bus.o_ALUout, bus.o_Ovf);
        end
    endtask

    task automatic run_mul(input int d, input string nm);
        int old;
        int cyc;
        bit got;
        old = m_r;
        model(1, d);
        issue(1, d);
        n_checks++;
        if ({bus.o_ALUout, bus.o_Busy, bus.o_Done} !== {old[7:0], 2'b10}) begin
            n_fail++;
            $display("FAIL %s_start: got %h", nm, act());
        end
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < W + 3) begin
            bus.i_Go = ($urandom_range(0, 1) == 1);
            bus.i_Function = 3'($urandom_range(0, 7));
            bus.i_Data = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
            cyc++;
            if (bus.o_Done) got = 1'b1;
            else begin
                n_checks++;
                if ({bus.o_ALUout, bus.o_Busy} !== {old[7:0], 1'b1}) begin
                    n_fail++;
                    $display("FAIL %s_hold: got %h", nm, act());
                end
            end
        end
        bus.i_Go = 1'b0;
        n_checks++;
        if (!got || cyc != W) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles done=%b want %0d", nm, cyc, got, W);
        end
        n_checks++;
        if (act() !== expv(1'b0, 1'b1)) begin
            n_fail++;
            $display("FAIL %s_result: got %h want %h", nm, act(), expv(1'b0, 1'b1));
        end
    endtask

    task automatic test_reset_mid_mul();
        single(5, 0, "rmm_and0");
        single(0, 13, "rmm_add");
        issue(1, 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_r = 0;
        m_ovf = 1'b0;
        n_checks++;
        if (act() !== '0) begin
            n_fail++;
            $display("FAIL rmm_abort: got %h want 0", act());
        end
        repeat (W) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (act() !== '0) begin
                n_fail++;
                $display("FAIL rmm_no_done: got %h want 0", act());
            end
        end
        single(0, 7, "rmm_add7");
        run_mul(9, "rmm_mul");
        n_checks++;
        if (bus.o_ALUout !== 8'h3F) begin
            n_fail++;
            $display("FAIL rmm_mul_lit: got %h want 3f", bus.o_ALUout);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            int f;
            int d;
            f = (i % 2 == 0) ? 0 : 7;
            d = $urandom_range(0, 15);
            single(f, d, "b2b_single");
        end
        single(5, 15, "b2b_mask");
        run_mul(6, "b2b_mul");
        single(0, 3, "b2b_after_mul");
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            int f;
            int d;
            f = $urandom_range(0, 7);
            d = $urandom_range(0, 15);
            if (f == 1) run_mul(d, "rnd_mul");
            else single(f, d, "rnd_single");
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                n_checks++;
                if (act() !== expv(1'b0, 1'b0)) begin
                    n_fail++;
                    $display("FAIL rnd_idle: got %h want %h", act(), expv(1'b0, 1'b0));
                end
            end
        end
    endtask

    initial begin
        bus.i_Go = 1'b0;
        bus.i_Function = 3'b000;
        bus.i_Data = '0;
        test_reset();
        test_add_shl();
        test_mul();
        test_ovf();
        test_sub();
        test_reset_mid_mul();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_accum_seq.md
# alu_accum_seq

Parametrised sequential accumulator ALU: a 2W-bit result register operated on by a W-bit data input under a 3-bit function select. It extends the 4-bit registered ALU with configurable width, a wider op set, and an overflow flag. It adds a Go/Busy/Done handshake so a multi-cycle shift-add multiplier can share the datapath. It sits between the switch/keypad input stage and the hex-display driver in the lab datapath.

## Interface
- W, default 4: data operand width; result register is 2W bits.
- Clock  input  1  sole clock; all state changes on posedge.
- Reset_b  input  1  synchronous, active-high reset (asserted = 1 resets on the next posedge).
- Go  input  1  issue request; sampled on posedge.
- Data  input  W  operand A.
- Function  input  3  op select, sampled with Go.
- ALUout  output  2W  result/accumulator register.
- Ovf  output  1  carry/borrow flag of last completed ADD/SUB.
- Busy  output  1  multiply in progress.
- Done  output  1  one-cycle pulse: result just written.

## Operation
- Issue: posedge with Go=1, Busy=0, Reset_b=0. Data and Function are latched at issue; later changes are ignored. Go while Busy=1 is dropped (not queued).
- Data is zero-extended to 2W bits. B = ALUout[W-1:0], R = ALUout.
- Function codes:
  - 000 ADD: R + Data mod 2^2W; Ovf = carry out.
  - 001 MUL: Data × B, exact 2W-bit product; multi-cycle.
  - 010 SHL: B << Data, truncated to 2W bits; shift ≥ 2W gives 0.
  - 011 HOLD: R unchanged; Done still pulses.
  - 100 SUB: R − Data mod 2^2W; Ovf = borrow.
  - 101 AND, 110 OR, 111 XOR: bitwise R op Data.
- Ovf is written only by ADD/SUB. Every other op clears it.
- MUL is a shift-add state machine.
  - States: IDLE → MUL → IDLE. MUL lasts exactly W cycles, with a counter from W−1 down to 0.
  - Multiplicand is latched B; multiplier is latched Data. Partial product is held internally.
  - ALUout keeps its old value until completion.
- Reset wins over everything. Reset during MUL aborts it: state IDLE, partial product discarded.

## Timing
- Reset values: ALUout=0, Ovf=0, Busy=0, Done=0, state IDLE, counter 0.
- Single-cycle ops issued at edge k:
  - ALUout and Ovf hold the new value after edge k.
  - Done=1 for the cycle after edge k only.
  - Busy stays 0.
- MUL issued at edge k:
  - Busy=1 after edge k, through edge k+W.
  - ALUout = product after edge k+W; Busy=0 and Done=1 in that same cycle.
  - Latency is W cycles from issue to result.
- Back-to-back issue:
  - Single-cycle ops: a new Go may be accepted every cycle.
  - MUL: the earliest next issue is edge k+W+1, where Busy is seen 0.
- Done is never high together with Busy.
- Done is never high two cycles in a row unless there are two back-to-back single-cycle issues.

## Configuration
- ALU_SAT_EN defined:
  - ADD saturates to all-ones on carry; SUB saturates to 0 on borrow.
  - Ovf is still set in both cases.
- ALU_SAT_EN undefined: ADD and SUB wrap modulo 2^2W.
- No other behaviour changes either way.

## Test plan
- Reset: drive Reset_b=1 for 2 cycles with Go=1 → ALUout=0x00, Ovf=0, Busy=0, Done=0.
- ADD then SHL, W=4, ALUout=0:
  - ADD Data=5 → ALUout=0x05, Done pulses 1 cycle.
  - SHL Data=3 → 0x28.
  - SHL Data=9 → 0x00.
- MUL, W=4, ALUout=0x0D, Data=0xB, Function=001:
  - Busy=1 for 4 cycles, ALUout holds 0x0D.
  - Then ALUout=0x8F, Done=1, Busy=0.
  - Go=1 with ADD during Busy is ignored.
- Overflow, ALUout=0xFE:
  - ADD Data=5 → 0x03, Ovf=1 (ALU_SAT_EN: 0xFF, Ovf=1).
  - Then AND Data=0xF → Ovf=0.
- SUB underflow, ALUout=0x02, SUB Data=4 → 0xFE, Ovf=1 (ALU_SAT_EN: 0x00).
- Reset mid-MUL: assert Reset_b at cycle 2 of a multiply → next cycle ALUout=0, Busy=0, no Done pulse. A fresh MUL afterwards completes correctly.
